// File: rtl/writeback.sv
// Commit stage: performs up to two destination writes in program order, then commits
// EIP/EFLAGS, counts the retirement and parks in HALT after a committed HLT.
module writeback #(
    parameter logic [31:0] RESET_EIP    = 32'h0000_0000,
    parameter logic [31:0] RESET_EFLAGS = 32'h0000_0002
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        exe_valid,
    output logic        exe_ready,
    input  logic [31:0] exe_next_eip,
    input  logic [31:0] exe_eflags,
    input  logic [31:0] exe_opnd0_w,
    input  logic [31:0] exe_opnd1_w,
    input  logic [1:0]  dest0_kind,
    input  logic [31:0] dest0_sel,
    input  logic [1:0]  dest1_kind,
    input  logic [31:0] dest1_sel,
    input  logic [1:0]  dest_size,
    input  logic        exe_halt,
    output logic        rf_we,
    output logic [2:0]  rf_sel,
    output logic [3:0]  rf_be,
    output logic [31:0] rf_data,
    output logic        mem_wr_valid,
    input  logic        mem_wr_ready,
    output logic [31:0] mem_wr_addr,
    output logic [1:0]  mem_wr_size,
    output logic [31:0] mem_wr_data,
    output logic [31:0] eip,
    output logic [31:0] eflags,
    output logic        retire,
    output logic [31:0] retire_count,
    output logic        halted
);

    localparam logic [1:0] KindReg = 2'd1;
    localparam logic [1:0] KindMem = 2'd2;

    // Bit 1 is reserved-set; bits 3 and 5 are reserved-clear.
    localparam logic [31:0] FlagsSet = 32'h0000_0002;
    localparam logic [31:0] FlagsClr = 32'h0000_0028;

    typedef enum logic [2:0] {StIdle, StWr0, StWr1, StCommit, StHalt} state_e;

    state_e state_q, state_d;

    logic [31:0] next_eip_q;
    logic [31:0] eflags_in_q;
    logic [31:0] data0_q;
    logic [31:0] data1_q;
    logic [1:0]  kind0_q;
    logic [1:0]  kind1_q;
    logic [31:0] sel0_q;
    logic [31:0] sel1_q;
    logic [1:0]  size_q;
    logic        halt_q;

    logic [31:0] eip_q;
    logic [31:0] eflags_q;
    logic [31:0] count_q;

    logic        accept;
    logic        in_wr;
    logic [1:0]  cur_kind;
    logic [31:0] cur_sel;
    logic [31:0] cur_data;
    logic        is_reg;
    logic        is_mem;

    assign accept = (state_q == StIdle) && exe_valid;

    // Select the destination being worked on from the latched copies.
    always_comb begin
        in_wr    = (state_q == StWr0) || (state_q == StWr1);
        cur_kind = (state_q == StWr1) ? kind1_q : kind0_q;
        cur_sel  = (state_q == StWr1) ? sel1_q  : sel0_q;
        cur_data = (state_q == StWr1) ? data1_q : data0_q;
        is_reg   = in_wr && (cur_kind == KindReg);
        is_mem   = in_wr && (cur_kind == KindMem);
    end

    // Register-file lane placement; 8-bit selects 4-7 address the high byte of regs 0-3.
    always_comb begin
        rf_we   = is_reg;
        rf_sel  = cur_sel[2:0];
        rf_be   = 4'b1111;
        rf_data = cur_data;
        case (size_q)
            2'd0: begin
                if (cur_sel[2]) begin
                    rf_sel  = {1'b0, cur_sel[1:0]};
                    rf_be   = 4'b0010;
                    rf_data = {16'b0, cur_data[7:0], 8'b0};
                end else begin
                    rf_be   = 4'b0001;
                    rf_data = {24'b0, cur_data[7:0]};
                end
            end
            2'd1: begin
                rf_be   = 4'b0011;
                rf_data = {16'b0, cur_data[15:0]};
            end
            default: begin
                rf_be   = 4'b1111;
                rf_data = cur_data;
            end
        endcase
    end

    // Memory request fields are held stable by the latched copies until acceptance.
    always_comb begin
        mem_wr_valid = is_mem;
        mem_wr_addr  = cur_sel;
        mem_wr_size  = size_q;
        mem_wr_data  = cur_data;
    end

    // Next-state: each write stage advances unless a memory request is still pending.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:   if (exe_valid) state_d = StWr0;
            StWr0:    if (!is_mem || mem_wr_ready) state_d = StWr1;
            StWr1:    if (!is_mem || mem_wr_ready) state_d = StCommit;
            StCommit: state_d = halt_q ? StHalt : StIdle;
            StHalt:   state_d = StHalt;
            default:  state_d = StIdle;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    // Capture the step on the accepting edge only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            next_eip_q  <= '0;
            eflags_in_q <= '0;
            data0_q     <= '0;
            data1_q     <= '0;
            kind0_q     <= '0;
            kind1_q     <= '0;
            sel0_q      <= '0;
            sel1_q      <= '0;
            size_q      <= '0;
            halt_q      <= 1'b0;
        end else if (accept) begin
            next_eip_q  <= exe_next_eip;
            eflags_in_q <= exe_eflags;
            data0_q     <= exe_opnd0_w;
            data1_q     <= exe_opnd1_w;
            kind0_q     <= dest0_kind;
            kind1_q     <= dest1_kind;
            sel0_q      <= dest0_sel;
            sel1_q      <= dest1_sel;
            size_q      <= dest_size;
            halt_q      <= exe_halt;
        end
    end

    // Architectural state updates once per committed step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            eip_q    <= RESET_EIP;
            eflags_q <= RESET_EFLAGS;
            count_q  <= '0;
        end else if (state_q == StCommit) begin
            eip_q    <= next_eip_q;
            eflags_q <= (eflags_in_q | FlagsSet) & ~FlagsClr;
            count_q  <= count_q + 32'd1;
        end
    end

    assign exe_ready    = (state_q == StIdle);
    assign retire       = (state_q == StCommit);
    assign halted       = (state_q == StHalt);
    assign eip          = eip_q;
    assign eflags       = eflags_q;
    assign retire_count = count_q;

endmodule

// File: tb/tb_writeback.sv
// Scoreboard bench for writeback: the driver pushes expected events, a negedge monitor pops them.
module tb_writeback;

    localparam logic [31:0] RST_EIP = 32'h0000_0000;
    localparam logic [31:0] RST_FL  = 32'h0000_0002;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        exe_valid = 1'b0;
    logic        exe_ready;
    logic [31:0] exe_next_eip = '0, exe_eflags = '0, exe_opnd0_w = '0, exe_opnd1_w = '0;
    logic [1:0]  dest0_kind = '0, dest1_kind = '0, dest_size = '0;
    logic [31:0] dest0_sel = '0, dest1_sel = '0;
    logic        exe_halt = 1'b0;
    logic        rf_we;
    logic [2:0]  rf_sel;
    logic [3:0]  rf_be;
    logic [31:0] rf_data;
    logic        mem_wr_valid;
    logic        mem_wr_ready = 1'b0;
    logic [31:0] mem_wr_addr;
    logic [1:0]  mem_wr_size;
    logic [31:0] mem_wr_data;
    logic [31:0] eip, eflags, retire_count;
    logic        retire, halted;

    writeback #(.RESET_EIP(RST_EIP), .RESET_EFLAGS(RST_FL)) dut (
        .clk(clk), .rst(rst), .exe_valid(exe_valid), .exe_ready(exe_ready),
        .exe_next_eip(exe_next_eip), .exe_eflags(exe_eflags),
        .exe_opnd0_w(exe_opnd0_w), .exe_opnd1_w(exe_opnd1_w),
        .dest0_kind(dest0_kind), .dest0_sel(dest0_sel),
        .dest1_kind(dest1_kind), .dest1_sel(dest1_sel),
        .dest_size(dest_size), .exe_halt(exe_halt),
        .rf_we(rf_we), .rf_sel(rf_sel), .rf_be(rf_be), .rf_data(rf_data),
        .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready),
        .mem_wr_addr(mem_wr_addr), .mem_wr_size(mem_wr_size), .mem_wr_data(mem_wr_data),
        .eip(eip), .eflags(eflags), .retire(retire), .retire_count(retire_count),
        .halted(halted)
    );

    always #5 clk = ~clk;

    // kind 0: reg write (sel, be, data); 1: mem write (addr, size, data); 2: commit (eip, fl, cnt)
    typedef struct {
        int          kind;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
    } ev_t;

    ev_t         sb[$];
    int          errors = 0;
    int          checks = 0;
    logic [31:0] model_count = '0;
    int          ready_mode = 0;  // 0 random, 1 accept after 3 waits, 2 never
    int          mem_vcnt = 0;
    int          last_mem_cycles = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference lane placement computed from byte arithmetic.
    function automatic void reg_model(input logic [31:0] sel, input logic [1:0] sz,
                                      input logic [31:0] d, output logic [31:0] osel,
                                      output logic [31:0] obe, output logic [31:0] odata);
        int idx;
        int lane;
        idx = int'(sel % 8);
        if (sz == 2'd0) begin
            lane  = idx / 4;
            osel  = 32'(idx % 4);
            obe   = 32'(1) << lane;
            odata = (d & 32'hFF) << (8 * lane);
        end else if (sz == 2'd1) begin
            osel  = 32'(idx);
            obe   = 32'h3;
            odata = d & 32'hFFFF;
        end else begin
            osel  = 32'(idx);
            obe   = 32'hF;
            odata = d;
        end
    endfunction

    task automatic push_dest(input logic [1:0] k, input logic [31:0] s, input logic [31:0] d,
                             input logic [1:0] sz);
        ev_t e;
        if (k == 2'd1) begin
            e.kind = 0;
            reg_model(s, sz, d, e.a, e.b, e.c);
            sb.push_back(e);
        end else if (k == 2'd2) begin
            e.kind = 1; e.a = s; e.b = 32'(sz); e.c = d;
            sb.push_back(e);
        end
    endtask

    task automatic issue(input logic [1:0] k0, input logic [31:0] s0, input logic [31:0] d0,
                         input logic [1:0] k1, input logic [31:0] s1, input logic [31:0] d1,
                         input logic [1:0] sz, input logic [31:0] neip, input logic [31:0] fl,
                         input logic h, input bit wait_done, output int lat);
        ev_t e;
        int  n;
        lat = -1;
        n = 0;
        @(posedge clk); #1;
        while (exe_ready !== 1'b1 && n < 300) begin @(posedge clk); #1; n++; end
        if (exe_ready !== 1'b1) begin
            chk("ready_timeout", {31'b0, exe_ready}, 32'd1);
            return;
        end
        exe_next_eip = neip; exe_eflags = fl; exe_opnd0_w = d0; exe_opnd1_w = d1;
        dest0_kind = k0; dest0_sel = s0; dest1_kind = k1; dest1_sel = s1;
        dest_size = sz; exe_halt = h; exe_valid = 1'b1;
        push_dest(k0, s0, d0, sz);
        push_dest(k1, s1, d1, sz);
        model_count = model_count + 1;
        e.kind = 2; e.a = neip; e.b = (fl | 32'h2) & ~32'h28; e.c = model_count;
        sb.push_back(e);
        @(posedge clk); #1;
        // Scramble inputs after acceptance: the DUT must ignore them.
        exe_valid = 1'b0;
        exe_next_eip = $urandom; exe_eflags = $urandom; exe_opnd0_w = $urandom;
        exe_opnd1_w = $urandom; dest0_kind = 2'($urandom); dest1_kind = 2'($urandom);
        dest0_sel = $urandom; dest1_sel = $urandom; dest_size = 2'($urandom);
        exe_halt = 1'($urandom);
        lat = 0;
        if (wait_done) begin
            while (exe_ready !== 1'b1 && lat < 300) begin @(posedge clk); #1; lat++; end
            if (exe_ready !== 1'b1) chk("done_timeout", {31'b0, exe_ready}, 32'd1);
        end
    endtask

    // Memory-ready driver, updated just after each rising edge.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (ready_mode == 0) begin
                mem_wr_ready = 1'($urandom);
            end else if (ready_mode == 1) begin
                if (mem_wr_valid) begin
                    mem_wr_ready = (mem_vcnt >= 3);
                    mem_vcnt = mem_wr_ready ? 0 : mem_vcnt + 1;
                end else begin
                    mem_wr_ready = 1'b0;
                    mem_vcnt = 0;
                end
            end else begin
                mem_wr_ready = 1'b0;
            end
        end
    end

    // Monitor: pops the scoreboard whenever the DUT presents an event.
    logic        pending = 1'b0;
    ev_t         pend_ev;
    logic        prev_wait = 1'b0;
    logic [31:0] prev_addr, prev_data;
    logic [1:0]  prev_size;
    int          vcycles = 0;

    initial begin
        ev_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                pending = 1'b0; prev_wait = 1'b0; vcycles = 0;
            end else begin
                if (pending) begin
                    chk("commit_eip", eip, pend_ev.a);
                    chk("commit_eflags", eflags, pend_ev.b);
                    chk("commit_count", retire_count, pend_ev.c);
                    pending = 1'b0;
                end
                if (prev_wait) begin
                    chk("mem_hold_valid", {31'b0, mem_wr_valid}, 32'd1);
                    chk("mem_hold_addr", mem_wr_addr, prev_addr);
                    chk("mem_hold_data", mem_wr_data, prev_data);
                    chk("mem_hold_size", 32'(mem_wr_size), 32'(prev_size));
                end
                if (rf_we || (mem_wr_valid && mem_wr_ready) || retire) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_event", 32'd1, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        if (rf_we) begin
                            chk("ev_kind_reg", 32'(e.kind), 32'd0);
                            chk("rf_sel", 32'(rf_sel), e.a);
                            chk("rf_be", 32'(rf_be), e.b);
                            chk("rf_data", rf_data, e.c);
                        end else if (retire) begin
                            chk("ev_kind_commit", 32'(e.kind), 32'd2);
                            pend_ev = e;
                            pending = 1'b1;
                        end else begin
                            chk("ev_kind_mem", 32'(e.kind), 32'd1);
                            chk("mem_addr", mem_wr_addr, e.a);
                            chk("mem_size", 32'(mem_wr_size), e.b);
                            chk("mem_data", mem_wr_data, e.c);
                        end
                    end
                end
                if (mem_wr_valid) vcycles++;
                if (mem_wr_valid && mem_wr_ready) begin
                    last_mem_cycles = vcycles;
                    vcycles = 0;
                end
                prev_wait = mem_wr_valid && !mem_wr_ready;
                prev_addr = mem_wr_addr;
                prev_data = mem_wr_data;
                prev_size = mem_wr_size;
            end
        end
    end

    initial begin
        int lat;
        logic [1:0] k0, k1, sz;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_eip", eip, RST_EIP);
        chk("rst_eflags", eflags, RST_FL);
        chk("rst_count", retire_count, 32'd0);
        chk("rst_halted", {31'b0, halted}, 32'd0);
        chk("rst_ready", {31'b0, exe_ready}, 32'd1);
        chk("rst_rf_we", {31'b0, rf_we}, 32'd0);
        chk("rst_mem_valid", {31'b0, mem_wr_valid}, 32'd0);
        chk("rst_retire", {31'b0, retire}, 32'd0);
        rst = 1'b0;

        // 32-bit register write, no second destination.
        issue(2'd1, 32'd0, 32'hDEADBEEF, 2'd0, 32'd0, 32'd0, 2'd2, 32'h1005, 32'h0, 1'b0,
              1'b1, lat);
        chk("lat_reg", 32'(lat), 32'd3);
        chk("eip_1005", eip, 32'h1005);
        chk("count_1", retire_count, 32'd1);

        // AH-style byte write.
        issue(2'd1, 32'd4, 32'h000000AB, 2'd0, 32'd0, 32'd0, 2'd0, 32'h1007, 32'h0, 1'b0,
              1'b1, lat);

        // PUSH-like step: memory held for 3 wait cycles, then register write.
        ready_mode = 1;
        issue(2'd2, 32'h7FFC, 32'h1234, 2'd1, 32'd4, 32'h7FFC, 2'd2, 32'h1008, 32'h0, 1'b0,
              1'b1, lat);
        chk("lat_push", 32'(lat), 32'd6);
        chk("push_mem_cycles", 32'(last_mem_cycles), 32'd4);
        ready_mode = 0;

        // Reserved flag bits and same-register ordering.
        issue(2'd1, 32'd2, 32'hAAAA5555, 2'd1, 32'd2, 32'hBBBB6666, 2'd2, 32'h2000,
              32'hFFFFFFFF, 1'b0, 1'b1, lat);
        #10;
        chk("eflags_forced", eflags, 32'hFFFFFFD7);

        // Random steps, random memory backpressure.
        for (int i = 0; i < 40; i++) begin
            k0 = 2'($urandom); k1 = 2'($urandom); sz = 2'($urandom);
            issue(k0, $urandom, $urandom, k1, $urandom, $urandom, sz, $urandom, $urandom,
                  1'b0, 1'b1, lat);
        end

        // Count wraps modulo 2^32.
        @(negedge clk);
        force dut.count_q = 32'hFFFFFFFF;
        @(negedge clk);
        release dut.count_q;
        model_count = 32'hFFFFFFFF;
        issue(2'd0, 32'd0, 32'd0, 2'd0, 32'd0, 32'd0, 2'd2, 32'h3000, 32'h0, 1'b0, 1'b1, lat);
        #10;
        chk("count_wrap", retire_count, 32'd0);

        // Reset while WR1 waits on memory: request drops, step is never committed.
        ready_mode = 2;
        issue(2'd0, 32'd0, 32'd0, 2'd2, 32'h100, 32'h55, 2'd2, 32'h4000, 32'h0, 1'b0, 1'b0,
              lat);
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("wr1_waiting", {31'b0, mem_wr_valid}, 32'd1);
        #2;
        rst = 1'b1;
        sb.delete();
        model_count = '0;
        #1;
        chk("rst_mid_mem_valid", {31'b0, mem_wr_valid}, 32'd0);
        chk("rst_mid_eip", eip, RST_EIP);
        chk("rst_mid_count", retire_count, 32'd0);
        chk("rst_mid_retire", {31'b0, retire}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        ready_mode = 0;

        // HLT commits then parks until reset.
        issue(2'd1, 32'd1, 32'h5, 2'd0, 32'd0, 32'd0, 2'd2, 32'h5000, 32'h0, 1'b1, 1'b0, lat);
        repeat (3) begin @(posedge clk); #1; end
        chk("halted_set", {31'b0, halted}, 32'd1);
        chk("halt_eip", eip, 32'h5000);
        exe_valid = 1'b1;
        repeat (4) begin
            @(posedge clk); #1;
            chk("halt_not_ready", {31'b0, exe_ready}, 32'd0);
        end
        exe_valid = 1'b0;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);
        rst = 1'b1;
        #3;
        chk("halt_rst_eip", eip, RST_EIP);
        chk("halt_rst_halted", {31'b0, halted}, 32'd0);
        chk("halt_rst_eflags", eflags, RST_FL);
        @(posedge clk); #1;
        rst = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
